// File: rtl/codec_ctrl_responder_pkg.sv
// Shared constants for the codec control responder: register addresses,
// register-file geometry and the power-on/reset value table.
package codec_ctrl_responder_pkg;

    localparam int unsigned NUM_REGS = 10;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 9;

    // Register addresses
    localparam logic [6:0] ADDR_LINVOL = 7'h00;  // left line-in volume
    localparam logic [6:0] ADDR_RINVOL = 7'h01;  // right line-in volume
    localparam logic [6:0] ADDR_LHPOUT = 7'h02;  // left headphone volume
    localparam logic [6:0] ADDR_RHPOUT = 7'h03;  // right headphone volume
    localparam logic [6:0] ADDR_APANA  = 7'h04;  // analogue path
    localparam logic [6:0] ADDR_DPATH  = 7'h05;  // digital path
    localparam logic [6:0] ADDR_PWR    = 7'h06;  // power down
    localparam logic [6:0] ADDR_IFACE  = 7'h07;  // digital interface format
    localparam logic [6:0] ADDR_SRATE  = 7'h08;  // sample rate
    localparam logic [6:0] ADDR_ACTIVE = 7'h09;  // interface activation
    localparam logic [6:0] RESET_ADDR  = 7'h0F;  // soft reset of the file

    // Data bit that mirrors a volume write into its stereo partner
    localparam int unsigned BOTH_BIT = 8;

    typedef logic [DATA_W-1:0] reg_file_t [NUM_REGS];

    localparam reg_file_t RESET_VALUES = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

endpackage

// File: rtl/codec_ctrl_responder_spi_word_rx.sv
// SPI word receiver: synchronises sck/mosi/cs into clk, detects edges,
// shifts in data on sck rising edges while cs is high, counts bits
// (saturating at 31) and reports each cs rising edge as a good (16 bits)
// or bad (any other count) word.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   spi_sck/mosi/cs      asynchronous serial inputs
//   word_ok              1-cycle strobe: cs rose with exactly 16 bits
//   word_bad             1-cycle strobe: cs rose with a wrong bit count
//   word                 current shift register contents
module spi_word_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    output logic        word_ok,
    output logic        word_bad,
    output logic [15:0] word
);
    import codec_ctrl_responder_pkg::*;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_hist;
    logic                   cs_hist;
    logic [15:0]            shreg;
    logic [4:0]             bit_cnt;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, cs_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign cs_rise  = cs_s & ~cs_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle levels, so no spurious edge is seen after reset
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_hist  <= 1'b0;
            cs_hist   <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_hist  <= sck_s;
            cs_hist   <= cs_s;

            // sck edges during the cs latch pulse are ignored
            if (sck_rise && cs_s) begin
                shreg <= {shreg[14:0], mosi_s};
            end

            // cs rise always restarts the count, even against a coincident sck edge
            if (cs_rise) begin
                bit_cnt <= '0;
            end else if (sck_rise && cs_s && bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    assign word_ok  = cs_rise && (bit_cnt == 5'd16);
    assign word_bad = cs_rise && (bit_cnt != 5'd16);
    assign word     = shreg;

endmodule

// File: rtl/codec_ctrl_responder.sv
// Codec control responder: receives 16-bit {addr[6:0], data[8:0]} words
// over a 3-wire SPI-style port and maintains a ten-entry 9-bit register
// file with stereo-pair mirroring, soft reset at 0x0F, a saturating error
// counter and a registered readback port.
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   spi_sck, spi_mosi, spi_cs    asynchronous serial configuration port
//   rd_addr / rd_data            readback address / registered data
//   word_valid                   pulse per accepted word
//   word_addr, word_data         last accepted word
//   frame_err                    pulse per wrong-length word
//   err_count                    saturating count of frame and address errors
//   active, iwl, fmt             decodes of registers 0x09 and 0x07
module codec_ctrl_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    input  logic             spi_cs,
    input  logic [6:0]       rd_addr,
    output logic [8:0]       rd_data,
    output logic             word_valid,
    output logic [6:0]       word_addr,
    output logic [8:0]       word_data,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic             active,
    output logic [1:0]       iwl,
    output logic [1:0]       fmt
);
    import codec_ctrl_responder_pkg::*;

    logic        rx_ok;
    logic        rx_bad;
    logic [15:0] rx_word;
    logic [6:0]  rx_addr;
    logic [8:0]  rx_data;
    logic        rx_in_file;
    logic        rx_is_reset;
    logic        rd_hit;
    logic        bump_err;

    reg_file_t   regs;

    spi_word_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_cs   (spi_cs),
        .word_ok  (rx_ok),
        .word_bad (rx_bad),
        .word     (rx_word)
    );

    assign rx_addr     = rx_word[15:9];
    assign rx_data     = rx_word[8:0];
    assign rx_in_file  = rx_addr < 7'(NUM_REGS);
    assign rx_is_reset = rx_addr == RESET_ADDR;
    assign rd_hit      = rd_addr < 7'(NUM_REGS);
    // Wrong-length frames and accepted words to unmapped addresses both count
    assign bump_err    = rx_bad || (rx_ok && !rx_in_file && !rx_is_reset);

    always_ff @(posedge clk) begin
        if (reset) begin
            regs       <= RESET_VALUES;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            word_addr  <= '0;
            word_data  <= '0;
            err_count  <= '0;
            rd_data    <= '0;
        end else begin
            word_valid <= rx_ok;
            frame_err  <= rx_bad;
            // Reads sample the file before this cycle's write lands
            rd_data    <= rd_hit ? regs[rd_addr[3:0]] : '0;

            if (rx_ok) begin
                word_addr <= rx_addr;
                word_data <= rx_data;
                if (rx_is_reset) begin
                    regs <= RESET_VALUES;
                end else if (rx_in_file) begin
                    regs[rx_addr[3:0]] <= rx_data;
                    if (rx_data[BOTH_BIT]) begin
                        case (rx_addr)
                            ADDR_LINVOL: regs[ADDR_RINVOL[3:0]] <= rx_data;
                            ADDR_RINVOL: regs[ADDR_LINVOL[3:0]] <= rx_data;
                            ADDR_LHPOUT: regs[ADDR_RHPOUT[3:0]] <= rx_data;
                            ADDR_RHPOUT: regs[ADDR_LHPOUT[3:0]] <= rx_data;
                            default: ;
                        endcase
                    end
                end
            end

            if (bump_err && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign active = regs[ADDR_ACTIVE[3:0]][0];
    assign iwl    = regs[ADDR_IFACE[3:0]][3:2];
    assign fmt    = regs[ADDR_IFACE[3:0]][1:0];

endmodule

// File: tb/tb_codec_ctrl_responder.sv
module tb_codec_ctrl_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs = 1'b1;
    logic [6:0] rd_addr = '0;
    logic [8:0] rd_data;
    logic       word_valid;
    logic [6:0] word_addr;
    logic [8:0] word_data;
    logic       frame_err;
    logic [7:0] err_count;
    logic       active;
    logic [1:0] iwl;
    logic [1:0] fmt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         is_err;
        logic [6:0] addr;
        logic [8:0] data;
    } ev_t;
    ev_t q[$];

    logic [8:0] exp_regs [10];
    logic [8:0] defaults [10];

    codec_ctrl_responder #(
        .SYNC_STAGES(2),
        .ERR_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .word_valid (word_valid),
        .word_addr  (word_addr),
        .word_data  (word_data),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .active     (active),
        .iwl        (iwl),
        .fmt        (fmt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every word_valid / frame_err pulse pops one expectation
    always @(negedge clk) begin
        if (!reset && (word_valid || frame_err)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: valid=%0b err=%0b addr=%0h data=%0h, none expected",
                         word_valid, frame_err, word_addr, word_data);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (frame_err !== e.is_err || word_valid !== !e.is_err ||
                    (!e.is_err && (word_addr !== e.addr || word_data !== e.data))) begin
                    errors++;
                    $display("FAIL event: got valid=%0b err=%0b addr=%0h data=%0h, expected err=%0b addr=%0h data=%0h",
                             word_valid, frame_err, word_addr, word_data, e.is_err, e.addr, e.data);
                end
            end
        end
    end

    task automatic expect_word(input logic [6:0] a, input logic [8:0] d);
        ev_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        q.push_back(e);
    endtask

    // Send the top n bits of val, MSB first; sck period 80 ns (8 clk)
    task automatic send_bits(input logic [15:0] val, input int n);
        for (int k = 0; k < n; k++) begin
            spi_mosi = val[15-k];
            #40 spi_sck = 1'b1;
            #40 spi_sck = 1'b0;
        end
    endtask

    task automatic cs_pulse();
        #40 spi_cs = 1'b0;
        #80 spi_cs = 1'b1;
        #80;
    endtask

    task automatic send_word(input logic [6:0] a, input logic [8:0] d);
        send_bits({a, d}, 16);
        cs_pulse();
    endtask

    task automatic read_check(input logic [6:0] a, input logic [8:0] exp, input string name);
        @(posedge clk); #1 rd_addr = a;
        @(posedge clk); #1;
        check(name, rd_data, exp);
    endtask

    task automatic check_file(input string tag);
        for (int i = 0; i < 10; i++) begin
            read_check(7'(i), exp_regs[i], $sformatf("%s_reg%0d", tag, i));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        defaults = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                     9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        exp_regs = defaults;

        // Reset state
        do_reset();
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_active", active, 0);
        check("rst_err_count", err_count, 0);
        check("rst_word_addr", word_addr, 0);
        check("rst_word_data", word_data, 0);
        check("rst_rd_data", rd_data, 0);
        @(posedge clk); #1 reset = 1'b0;
        check("rst_iwl", iwl, 2'b10);
        check("rst_fmt", fmt, 2'b10);
        check_file("rst");
        read_check(7'h0A, 9'h000, "rd_out_of_range_0a");
        read_check(7'h7F, 9'h000, "rd_out_of_range_7f");

        // Word 0x1201: addr 0x09, data 0x001
        expect_word(7'h09, 9'h001);
        send_bits(16'h1201, 16);
        cs_pulse();
        exp_regs[9] = 9'h001;
        check("active_set", active, 1);
        read_check(7'h09, 9'h001, "rd_reg9");

        // Stereo mirroring
        expect_word(7'h00, 9'h11F);
        send_word(7'h00, 9'h11F);
        exp_regs[0] = 9'h11F; exp_regs[1] = 9'h11F;
        read_check(7'h00, 9'h11F, "both_reg0");
        read_check(7'h01, 9'h11F, "both_reg1");
        expect_word(7'h03, 9'h1AB);
        send_word(7'h03, 9'h1AB);
        exp_regs[2] = 9'h1AB; exp_regs[3] = 9'h1AB;
        expect_word(7'h02, 9'h055);
        send_word(7'h02, 9'h055);
        exp_regs[2] = 9'h055;
        check_file("pair");

        // 15-bit frame rejected, then a good word
        expect_err();
        send_bits(16'h0AAA, 15);
        cs_pulse();
        check("short_err_count", err_count, 1);
        check_file("short");
        expect_word(7'h05, 9'h0AA);
        send_word(7'h05, 9'h0AA);
        exp_regs[5] = 9'h0AA;
        read_check(7'h05, 9'h0AA, "after_short_reg5");
        check("after_short_err_count", err_count, 1);

        // Interface register, then soft reset via 0x0F
        expect_word(7'h07, 9'h04B);
        send_word(7'h07, 9'h04B);
        exp_regs[7] = 9'h04B;
        check("iface_iwl", iwl, 2'b10);
        check("iface_fmt", fmt, 2'b11);
        expect_word(7'h0F, 9'h123);
        send_word(7'h0F, 9'h123);
        exp_regs = defaults;
        check_file("softrst");
        check("softrst_iwl", iwl, 2'b10);
        check("softrst_fmt", fmt, 2'b10);
        check("softrst_active", active, 0);
        check("softrst_err_count", err_count, 1);

        // Unmapped address
        expect_word(7'h0B, 9'h077);
        send_word(7'h0B, 9'h077);
        check("badaddr_err_count", err_count, 2);
        check_file("badaddr");

        // Saturation: 300 empty frames
        for (int i = 0; i < 300; i++) begin
            expect_err();
            cs_pulse();
        end
        check("sat_err_count", err_count, 255);

        // Reset mid-word
        expect_word(7'h04, 9'h1FF);
        send_word(7'h04, 9'h1FF);
        read_check(7'h04, 9'h1FF, "pre_reset_reg4");
        send_bits(16'hA5A5, 8);
        #200;
        do_reset();
        @(posedge clk); #1 reset = 1'b0;
        exp_regs = defaults;
        check("midrst_err_count", err_count, 0);
        check_file("midrst");
        expect_err();
        cs_pulse();
        check("midrst_frame_err_count", err_count, 1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codec_ctrl_responder.md
CODEC_CTRL_RESPONDER -- requirements
Module: codec_ctrl_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on each SPI input (min 2).
REQ-002 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 spi_sck  input  1  serial clock from the configuration master, asynchronous to clk.
REQ-006 spi_mosi  input  1  serial data, MSB first, asynchronous.
REQ-007 spi_cs  input  1  latch strobe, idle high, asynchronous; a low pulse ends each word.
REQ-008 rd_addr  input  7  register readback address.
REQ-009 rd_data  output  9  registered readback data.
REQ-010 word_valid  output  1  one-cycle pulse per accepted word.
REQ-011 word_addr  output  7  address of the last accepted word.
REQ-012 word_data  output  9  data of the last accepted word.
REQ-013 frame_err  output  1  one-cycle pulse per rejected latch.
REQ-014 err_count  output  ERR_W  saturating count of frame errors and bad addresses.
REQ-015 active  output  1  bit 0 of register 0x09.
REQ-016 iwl  output  2  bits [3:2] of register 0x07; fmt  output  2  bits [1:0] of register 0x07.

Function
REQ-017 Each SPI input passes through SYNC_STAGES flops plus one history flop; edges are detected on the synchronised signals; clk is at least 4x the SCK frequency.
REQ-018 On every synchronised SCK rising edge: shift {shreg[14:0], mosi_sync} into a 16-bit shift register; increment a 5-bit bit counter that saturates at 31.
REQ-019 On a synchronised CS rising edge with bit counter == 16: accept the word; addr = shreg[15:9], data = shreg[8:0].
REQ-020 On a CS rising edge with bit counter != 16: reject the word; pulse frame_err; increment err_count; leave registers unchanged.
REQ-021 Every CS rising edge clears the bit counter; the shift register is not cleared.
REQ-022 SCK edges arriving while the synchronised CS is low are ignored.
REQ-023 Register file: ten 9-bit registers at addresses 0x00-0x09; reset values 0x097, 0x097, 0x079, 0x079, 0x00A, 0x008, 0x09F, 0x00A, 0x000, 0x000.
REQ-024 Accepted word to 0x00-0x09 writes data on the cycle after the CS edge; word_valid, word_addr and word_data update on that same cycle.
REQ-025 Write to 0x00 with data[8]=1 also writes 0x01 with identical data; write to 0x01 with data[8]=1 also writes 0x00; 0x02/0x03 pair identically.
REQ-026 Accepted word to 0x0F resets all ten registers to the REQ-023 values regardless of data; word_valid pulses.
REQ-027 Accepted word to any other address: no register change; word_valid pulses; err_count increments; frame_err does not pulse.
REQ-028 err_count saturates at all-ones and never wraps.
REQ-029 rd_data = register[rd_addr] one cycle after rd_addr is applied; addresses outside 0x00-0x09 read 0x000.
REQ-030 A readback in the cycle of a write returns the pre-write value.
REQ-031 active, iwl and fmt are combinational decodes of the registered file.

Reset
REQ-032 Reset loads the REQ-023 values, clears the shift register, bit counter, err_count, word_addr, word_data and rd_data, and sets synchroniser flops to idle (sck 0, cs 1, mosi 0).
REQ-033 Reset mid-word discards the partial word; the next CS rising edge after reset is rejected unless 16 SCK edges have been seen.
REQ-034 word_valid, frame_err and active are 0 out of reset.

Structure
REQ-035 A shared package holds the register address constants, the reset-value table, NUM_REGS = 10 and RESET_ADDR = 0x0F.
REQ-036 One sub-module, spi_word_rx, contains the synchronisers, edge detect, shift register and bit counter, and outputs a word/length-ok strobe; the register file and decode stay in the top.

Verification
REQ-037 Send 16 bits 0x1201 (addr 0x09, data 0x001), then a CS pulse -> word_valid once; active=1; rd_addr 0x09 -> rd_data 0x001.
REQ-038 Send addr 0x00, data 0x11F (LRINBOTH set) -> registers 0x00 and 0x01 both read 0x11F.
REQ-039 Send 15 bits, then a CS pulse -> frame_err once; err_count=1; no register change; then a valid 16-bit word -> accepted.
REQ-040 Write 0x07=0x04B, then send addr 0x0F -> every register reads back its reset value; iwl=2'b10, fmt=2'b10.
REQ-041 Send addr 0x0B -> word_valid; err_count increments; file unchanged; force 300 errors with ERR_W=8 -> err_count holds 255.
REQ-042 Assert reset after 8 bits -> registers at defaults; a following CS pulse -> frame_err.
